// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the PWM power controllers.
package pwm_ctrl_pkg;

    localparam int unsigned POWER_W        = 8;
    localparam int unsigned EXT_W          = POWER_W + 1;
    localparam int unsigned RATE_W         = 4;
    localparam int unsigned CNT_W          = 16;
    localparam int unsigned DEFAULT_PERIOD = 50000;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } pwm_state_e;

    // Move cur one step toward tgt, landing exactly on tgt instead of overshooting.
    function automatic logic [POWER_W-1:0] sat_step(
        input logic [POWER_W-1:0] cur,
        input logic [POWER_W-1:0] tgt,
        input logic [POWER_W-1:0] step
    );
        logic [EXT_W-1:0]   gap;
        logic [POWER_W-1:0] nxt;
        gap = '0;
        nxt = cur;
        if (cur < tgt) begin
            gap = EXT_W'(tgt) - EXT_W'(cur);
            nxt = (gap <= EXT_W'(step)) ? tgt : cur + step;
        end else if (cur > tgt) begin
            gap = EXT_W'(cur) - EXT_W'(tgt);
            nxt = (gap <= EXT_W'(step)) ? tgt : cur - step;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter; period_tick marks the last clock of each period.
module pwm_period_timer
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned PERIOD = DEFAULT_PERIOD
) (
    input  logic clock,
    input  logic reset,
    output logic period_tick
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = (count_q == CNT_W'(PERIOD - 1)) ? '0 : count_q + CNT_W'(1);
    end

    // Tick is registered so it is high exactly while the counter holds PERIOD-1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            period_tick <= 1'b0;
        end else begin
            count_q     <= count_d;
            period_tick <= (count_d == CNT_W'(PERIOD - 1));
        end
    end

endmodule

// File: rtl/pwm_ramp_scheduler.sv
// Multi-channel power ramp scheduler: accepts target commands while idle and
// slews every channel once per PWM period with a single time-shared update engine.
module pwm_ramp_scheduler
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned PERIOD = DEFAULT_PERIOD,
    parameter int unsigned STEP   = 1,
    localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [CH_W-1:0]           cmd_ch,
    input  logic [POWER_W-1:0]        cmd_target,
    input  logic [RATE_W-1:0]         cmd_rate,
    input  logic                      cmd_immediate,
    output logic [NUM_CH*POWER_W-1:0] power_out,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         ramp_done,
    output logic                      period_tick
);

    pwm_state_e         state_q, state_d;
    logic [CH_W-1:0]    idx_q, idx_d;
    logic [POWER_W-1:0] power_q  [NUM_CH];
    logic [POWER_W-1:0] power_d  [NUM_CH];
    logic [POWER_W-1:0] target_q [NUM_CH];
    logic [POWER_W-1:0] target_d [NUM_CH];
    logic [RATE_W-1:0]  rate_q   [NUM_CH];
    logic [RATE_W-1:0]  rate_d   [NUM_CH];
    logic [RATE_W-1:0]  rcnt_q   [NUM_CH];
    logic [RATE_W-1:0]  rcnt_d   [NUM_CH];
    logic [NUM_CH-1:0]  busy_d;
    logic [NUM_CH-1:0]  done_d;
    logic [POWER_W-1:0] stepped;
    logic               accept;

    pwm_period_timer #(
        .PERIOD(PERIOD)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .period_tick(period_tick)
    );

    assign accept = cmd_valid && cmd_ready;

    // Next-state: commands land only in IDLE, so they never race the sweep engine.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        power_d  = power_q;
        target_d = target_q;
        rate_d   = rate_q;
        rcnt_d   = rcnt_q;
        done_d   = '0;
        busy_d   = '0;
        stepped  = sat_step(power_q[idx_q], target_q[idx_q], POWER_W'(STEP));

        case (state_q)
            IDLE: begin
                if (accept) begin
                    target_d[cmd_ch] = cmd_target;
                    rate_d[cmd_ch]   = cmd_rate;
                    rcnt_d[cmd_ch]   = '0;
                    if (cmd_immediate) begin
                        power_d[cmd_ch] = cmd_target;
                    end
                end
                if (period_tick) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                if (power_q[idx_q] != target_q[idx_q]) begin
                    if (rcnt_q[idx_q] != '0) begin
                        rcnt_d[idx_q] = rcnt_q[idx_q] - RATE_W'(1);
                    end else begin
                        rcnt_d[idx_q]  = rate_q[idx_q];
                        power_d[idx_q] = stepped;
                        done_d[idx_q]  = (stepped == target_q[idx_q]);
                    end
                end
                if (idx_q == CH_W'(NUM_CH - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + CH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        for (int n = 0; n < NUM_CH; n++) begin
            busy_d[n] = (power_d[n] != target_d[n]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cmd_ready <= 1'b1;
            busy      <= '0;
            ramp_done <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                power_q[n]  <= '0;
                target_q[n] <= '0;
                rate_q[n]   <= '0;
                rcnt_q[n]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cmd_ready <= (state_d == IDLE);
            busy      <= busy_d;
            ramp_done <= done_d;
            power_q   <= power_d;
            target_q  <= target_d;
            rate_q    <= rate_d;
            rcnt_q    <= rcnt_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign power_out[g*POWER_W +: POWER_W] = power_q[g];
    end

endmodule
